ber_window_monitor: RTL and testbench
=====================================

// Module: ber_window_monitor
// PURPOSE
// - Downstream of the IQ BER counter: converts its free-running cumulative error/bit counters into fixed-length
//   windowed error counts, runs a lock/loss FSM on them, and hands each window result to the register/report
//   interface over a valid/ready handshake.
// - Also tracks rotation-angle changes from the phase detector and restarts acquisition on any change.
// PARAMETERS
// CNT_W      64    width of the upstream cumulative counters
// WIN_BITS   4096  evaluated bits (I channel) per window; >=2
// ERR_THR    40    window is GOOD when err_I+err_Q <= ERR_THR
// LOCK_WINS  3     consecutive GOOD windows to enter LOCKED
// LOSS_WINS  2     consecutive BAD windows in LOCKED to drop to ACQ
// IDX_W      16    width of window index / loss counter
// PORTS
// i_clock        in   1        system clock
// i_reset        in   1        synchronous, active-high reset
// i_en           in   1        1: monitor runs; 0: all state, snapshots and outputs hold
// i_err_cnt_I    in   CNT_W    cumulative bit errors, I channel
// i_err_cnt_Q    in   CNT_W    cumulative bit errors, Q channel
// i_bit_cnt_I    in   CNT_W    cumulative evaluated bits, I (increments by at most 1/cycle)
// i_rot_ang      in   2        detected rotation (00/01/10/11 = 0/90/180/270)
// i_win_ready    in   1        consumer accepts window result
// o_win_valid    out  1        window result pending
// o_win_err_I    out  WE       window errors I, WE = $clog2(WIN_BITS+1)
// o_win_err_Q    out  WE       window errors Q
// o_win_rot      out  2        rotation in force during the window
// o_win_idx      out  IDX_W    index of the window (wraps mod 2^IDX_W)
// o_state        out  2        FSM state encoding
// o_locked       out  1        o_state==LOCKED
// o_rot_change   out  1        1-cycle pulse on rotation change
// o_overrun      out  1        sticky: result overwritten before acceptance
// o_loss_cnt     out  IDX_W    LOCKED->ACQ transitions, saturating
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, snapshots 0, rot_q=00, good_run=bad_run=0.
// - All deltas: cur - snapshot, modulo 2^CNT_W (wrap-safe); err deltas truncated to WE bits (cannot exceed WIN_BITS).
// - IDLE: first cycle with i_en=1 -> snapshots <= current inputs, rot_q <= i_rot_ang, goto ACQ. No result.
// - Window close (ACQ or LOCKED, i_en=1): cycle k where bit delta >= WIN_BITS. At edge k+1:
//   - o_win_valid=1 with err deltas sampled at k, o_win_rot=rot_q, o_win_idx=previous idx+1 (first window = 1).
//   - Snapshots <= inputs sampled at k.
// - Window classification (GOOD = err_I+err_Q <= ERR_THR, sum width WE+1):
//   - ACQ: GOOD -> good_run++, else good_run=0; good_run reaching LOCK_WINS -> LOCKED, bad_run=0.
//   - LOCKED: BAD -> bad_run++, GOOD -> bad_run=0; bad_run reaching LOSS_WINS -> ACQ, good_run=0,
//     o_loss_cnt++ (saturates at all-ones).
//   - State/run updates happen on the same edge as o_win_valid.
// - Rotation change: i_rot_ang != rot_q in cycle k (i_en=1, not IDLE). At k+1:
//   - rot_q updated, o_rot_change=1 for one cycle, snapshots <= current inputs (window aborted).
//   - good_run=bad_run=0, state ACQ. No loss_cnt increment.
// - Simultaneous window close and rotation change: change wins; no result, no classification.
// - Handshake: result held stable while o_win_valid && !i_win_ready; cleared on the edge after valid&&ready.
//   - New close while pending and not accepted this cycle: overwrite, set o_overrun (sticky until reset).
//   - Close in the same cycle as acceptance: new result loads, valid stays 1, no overrun.
// - i_en=0: nothing advances, including handshake-independent state; valid/ready acceptance still honoured.
// - Reset mid-window or mid-handshake: pending result discarded, return to IDLE.
// - States: IDLE=2'b00, ACQ=2'b01, LOCKED=2'b10; 2'b11 unreachable, recovers to IDLE.
// STRUCTURE
// - ber_pkg: state localparams, rotation codes, GOOD compare helper; WE derived locally via $clog2.
// - Sub-module ber_delta_snap (snapshot register + wrap-safe subtractor), instantiated 3x (err_I, err_Q, bit_I).
// - Top holds FSM, run counters, result/handshake registers.
// TESTING
// - Defaults, inputs start 0, bit_cnt +1/cycle, no errors -> valid at cycles 4096/8192/12288 after ACQ, LOCKED after 3rd.
// - Locked, inject 50 Q errors in each of 2 windows -> ACQ on 2nd close, o_loss_cnt=1; 1 bad window only -> stays LOCKED.
// - Counters preset to 2^64-100 then wrap through 0 -> window err/bit deltas exact, no spurious close.
// - Rotation 00->10 mid-window in LOCKED -> o_rot_change pulse, ACQ, next window starts full 4096 bits later.
// - i_win_ready=0 over two closes -> o_overrun=1, second result shown; ready=1 on close cycle -> valid stays high, no overrun.
// - Reset asserted mid-window with valid pending -> all outputs 0 next cycle, IDLE, o_win_idx restarts at 1.

Source files
------------

// File: rtl/ber_pkg.sv
// ber_pkg
// Shared definitions for the BER window monitor:
//   - ber_state_e : lock/loss FSM encoding (2'b11 is unused and recovers to IDLE)
//   - ROT_*       : rotation codes reported by the phase detector
//   - ber_is_good : window classification (sum of I and Q errors against a threshold)
package ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACQ    = 2'b01,
        ST_LOCKED = 2'b10
    } ber_state_e;

    localparam logic [1:0] ROT_0   = 2'b00;
    localparam logic [1:0] ROT_90  = 2'b01;
    localparam logic [1:0] ROT_180 = 2'b10;
    localparam logic [1:0] ROT_270 = 2'b11;

    // GOOD when err_i + err_q <= thr. The sum is one bit wider than the
    // operands so it can never wrap and turn a bad window into a good one.
    function automatic logic ber_is_good(input logic [31:0] err_i,
                                         input logic [31:0] err_q,
                                         input logic [31:0] thr);
        logic [32:0] sum;
        sum = {1'b0, err_i} + {1'b0, err_q};
        return (sum <= {1'b0, thr});
    endfunction

endpackage

// File: rtl/ber_delta_snap.sv
// ber_delta_snap
// Holds a snapshot of a free-running cumulative counter and reports how far
// the counter has moved since the snapshot, modulo 2^W, so a counter that
// wraps through zero still yields the exact distance.
// Ports:
//   i_clock  in   1       system clock
//   i_reset  in   1       synchronous, active-high; snapshot clears to 0
//   i_load   in   1       capture i_cur as the new snapshot at this edge
//   i_cur    in   W       current counter value
//   o_delta  out  OUT_W   (i_cur - snapshot) mod 2^W, truncated to OUT_W bits
module ber_delta_snap #(
    parameter int W     = 64,
    parameter int OUT_W = 64
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [W-1:0]     i_cur,
    output logic [OUT_W-1:0] o_delta
);

    logic [W-1:0] snap_q;
    logic [W-1:0] snap_d;

    always_comb begin
        snap_d = snap_q;
        if (i_load) begin
            snap_d = i_cur;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    // Unsigned subtraction is already modulo 2^W; truncation keeps the low bits.
    assign o_delta = OUT_W'(i_cur - snap_q);

endmodule

// File: rtl/ber_window_monitor.sv
// ber_window_monitor
// Turns the upstream cumulative error/bit counters into fixed-length window
// error counts, runs a lock/loss FSM on those windows, and presents each
// window result on a valid/ready interface. A change of detected rotation
// aborts the current window and restarts acquisition.
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_en                     1: monitor runs; 0: everything holds (handshake still honoured)
//   i_err_cnt_I/Q            cumulative bit errors per channel (CNT_W)
//   i_bit_cnt_I              cumulative evaluated bits, I channel (CNT_W)
//   i_rot_ang                detected rotation code
//   i_win_ready              consumer accepts the pending result
//   o_win_valid              result pending
//   o_win_err_I/Q            window errors (WE = $clog2(WIN_BITS+1) bits)
//   o_win_rot                rotation in force during the window
//   o_win_idx                window index, first window = 1, wraps
//   o_state, o_locked        FSM state and LOCKED flag
//   o_rot_change             one-cycle pulse on rotation change
//   o_overrun                sticky: a result was overwritten before acceptance
//   o_loss_cnt               saturating count of LOCKED->ACQ transitions
module ber_window_monitor
    import ber_pkg::*;
#(
    parameter int CNT_W     = 64,
    parameter int WIN_BITS  = 4096,
    parameter int ERR_THR   = 40,
    parameter int LOCK_WINS = 3,
    parameter int LOSS_WINS = 2,
    parameter int IDX_W     = 16,
    localparam int WE       = $clog2(WIN_BITS + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_err_cnt_I,
    input  logic [CNT_W-1:0] i_err_cnt_Q,
    input  logic [CNT_W-1:0] i_bit_cnt_I,
    input  logic [1:0]       i_rot_ang,
    input  logic             i_win_ready,
    output logic             o_win_valid,
    output logic [WE-1:0]    o_win_err_I,
    output logic [WE-1:0]    o_win_err_Q,
    output logic [1:0]       o_win_rot,
    output logic [IDX_W-1:0] o_win_idx,
    output logic [1:0]       o_state,
    output logic             o_locked,
    output logic             o_rot_change,
    output logic             o_overrun,
    output logic [IDX_W-1:0] o_loss_cnt
);

    localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(WIN_BITS);
    localparam logic [IDX_W-1:0] LOCK_N   = IDX_W'(LOCK_WINS);
    localparam logic [IDX_W-1:0] LOSS_N   = IDX_W'(LOSS_WINS);

    // ------------------------------------------------------------------
    // Snapshot/delta units
    // ------------------------------------------------------------------
    logic             load_snap;
    logic [WE-1:0]    err_i_delta;
    logic [WE-1:0]    err_q_delta;
    logic [CNT_W-1:0] bit_delta;

    ber_delta_snap #(.W(CNT_W), .OUT_W(WE)) u_snap_err_i (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (load_snap),
        .i_cur   (i_err_cnt_I),
        .o_delta (err_i_delta)
    );

    ber_delta_snap #(.W(CNT_W), .OUT_W(WE)) u_snap_err_q (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (load_snap),
        .i_cur   (i_err_cnt_Q),
        .o_delta (err_q_delta)
    );

    ber_delta_snap #(.W(CNT_W), .OUT_W(CNT_W)) u_snap_bit_i (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (load_snap),
        .i_cur   (i_bit_cnt_I),
        .o_delta (bit_delta)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ber_state_e       state_q,      state_d;
    logic [1:0]       rot_q,        rot_d;
    logic [IDX_W-1:0] good_run_q,   good_run_d;
    logic [IDX_W-1:0] bad_run_q,    bad_run_d;
    logic             valid_q,      valid_d;
    logic [WE-1:0]    win_err_i_q,  win_err_i_d;
    logic [WE-1:0]    win_err_q_q,  win_err_q_d;
    logic [1:0]       win_rot_q,    win_rot_d;
    logic [IDX_W-1:0] win_idx_q,    win_idx_d;
    logic             rot_change_q, rot_change_d;
    logic             overrun_q,    overrun_d;
    logic [IDX_W-1:0] loss_cnt_q,   loss_cnt_d;

    logic             win_close;
    logic             rot_diff;
    logic             win_good;
    logic             accept;
    logic [IDX_W-1:0] good_run_inc;
    logic [IDX_W-1:0] bad_run_inc;

    assign win_close    = (bit_delta >= WIN_LEN);
    assign rot_diff     = (i_rot_ang != rot_q);
    assign win_good     = ber_is_good(32'(err_i_delta), 32'(err_q_delta), 32'(ERR_THR));
    assign good_run_inc = good_run_q + 1'b1;
    assign bad_run_inc  = bad_run_q + 1'b1;

    // Handshake: a result is transferred on any edge where o_win_valid and
    // i_win_ready are both high; the result registers stay stable while
    // o_win_valid is high and i_win_ready is low. Acceptance works even when
    // i_en is low, and a new window result may load on the same edge as the
    // acceptance of the previous one.
    assign accept = valid_q && i_win_ready;

    always_comb begin
        state_d      = state_q;
        rot_d        = rot_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        valid_d      = valid_q && !accept;
        win_err_i_d  = win_err_i_q;
        win_err_q_d  = win_err_q_q;
        win_rot_d    = win_rot_q;
        win_idx_d    = win_idx_q;
        rot_change_d = 1'b0;
        overrun_d    = overrun_q;
        loss_cnt_d   = loss_cnt_q;
        load_snap    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    load_snap = 1'b1;
                    rot_d     = i_rot_ang;
                    state_d   = ST_ACQ;
                end
            end

            ST_ACQ, ST_LOCKED: begin
                if (i_en) begin
                    // A rotation change takes priority over a coinciding
                    // window close: the window is simply thrown away.
                    if (rot_diff) begin
                        load_snap    = 1'b1;
                        rot_d        = i_rot_ang;
                        rot_change_d = 1'b1;
                        good_run_d   = '0;
                        bad_run_d    = '0;
                        state_d      = ST_ACQ;
                    end else if (win_close) begin
                        load_snap   = 1'b1;
                        valid_d     = 1'b1;
                        win_err_i_d = err_i_delta;
                        win_err_q_d = err_q_delta;
                        win_rot_d   = rot_q;
                        win_idx_d   = win_idx_q + 1'b1;
                        if (valid_q && !i_win_ready) begin
                            overrun_d = 1'b1;
                        end

                        if (state_q == ST_ACQ) begin
                            if (win_good) begin
                                good_run_d = good_run_inc;
                                if (good_run_inc >= LOCK_N) begin
                                    state_d   = ST_LOCKED;
                                    bad_run_d = '0;
                                end
                            end else begin
                                good_run_d = '0;
                            end
                        end else begin
                            if (win_good) begin
                                bad_run_d = '0;
                            end else begin
                                bad_run_d = bad_run_inc;
                                if (bad_run_inc >= LOSS_N) begin
                                    state_d    = ST_ACQ;
                                    good_run_d = '0;
                                    bad_run_d  = '0;
                                    if (loss_cnt_q != '1) begin
                                        loss_cnt_d = loss_cnt_q + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                good_run_d = '0;
                bad_run_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            rot_q        <= '0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            valid_q      <= 1'b0;
            win_err_i_q  <= '0;
            win_err_q_q  <= '0;
            win_rot_q    <= '0;
            win_idx_q    <= '0;
            rot_change_q <= 1'b0;
            overrun_q    <= 1'b0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rot_q        <= rot_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            valid_q      <= valid_d;
            win_err_i_q  <= win_err_i_d;
            win_err_q_q  <= win_err_q_d;
            win_rot_q    <= win_rot_d;
            win_idx_q    <= win_idx_d;
            rot_change_q <= rot_change_d;
            overrun_q    <= overrun_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign o_win_valid  = valid_q;
    assign o_win_err_I  = win_err_i_q;
    assign o_win_err_Q  = win_err_q_q;
    assign o_win_rot    = win_rot_q;
    assign o_win_idx    = win_idx_q;
    assign o_state      = state_q;
    assign o_locked     = (state_q == ST_LOCKED);
    assign o_rot_change = rot_change_q;
    assign o_overrun    = overrun_q;
    assign o_loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_ber_window_monitor.sv
module tb_ber_window_monitor;

    localparam int WIN_BITS = 4096;
    localparam int WE       = 13;

    logic          i_clock;
    logic          i_reset;
    logic          i_en;
    logic [63:0]   i_err_cnt_I;
    logic [63:0]   i_err_cnt_Q;
    logic [63:0]   i_bit_cnt_I;
    logic [1:0]    i_rot_ang;
    logic          i_win_ready;
    logic          o_win_valid;
    logic [WE-1:0] o_win_err_I;
    logic [WE-1:0] o_win_err_Q;
    logic [1:0]    o_win_rot;
    logic [15:0]   o_win_idx;
    logic [1:0]    o_state;
    logic          o_locked;
    logic          o_rot_change;
    logic          o_overrun;
    logic [15:0]   o_loss_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_close   = 0;

    ber_window_monitor dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_en         (i_en),
        .i_err_cnt_I  (i_err_cnt_I),
        .i_err_cnt_Q  (i_err_cnt_Q),
        .i_bit_cnt_I  (i_bit_cnt_I),
        .i_rot_ang    (i_rot_ang),
        .i_win_ready  (i_win_ready),
        .o_win_valid  (o_win_valid),
        .o_win_err_I  (o_win_err_I),
        .o_win_err_Q  (o_win_err_Q),
        .o_win_rot    (o_win_rot),
        .o_win_idx    (o_win_idx),
        .o_state      (o_state),
        .o_locked     (o_locked),
        .o_rot_change (o_rot_change),
        .o_overrun    (o_overrun),
        .o_loss_cnt   (o_loss_cnt)
    );

    // clock
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, and the
    // upstream bit counter advances by one evaluated bit per cycle.
    task automatic tick();
        @(posedge i_clock);
        #1;
        cyc++;
        i_bit_cnt_I = i_bit_cnt_I + 64'd1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Inject ei/eq errors into the window that just began, wait for the next
    // window result (bounded), and check its length, payload and index.
    // late_rdy raises i_win_ready only for the cycle in which the window closes.
    task automatic run_window(input string tag, input logic [12:0] ei, input logic [12:0] eq,
                              input bit late_rdy, input logic [15:0] exp_idx);
        logic [15:0] prev;
        int n;
        prev = o_win_idx;
        i_err_cnt_I = i_err_cnt_I + 64'(ei);
        i_err_cnt_Q = i_err_cnt_Q + 64'(eq);
        n = 0;
        while (o_win_idx === prev && n < WIN_BITS + 16) begin
            if (late_rdy && (cyc - last_close) == WIN_BITS - 1) i_win_ready = 1'b1;
            tick();
            n++;
        end
        check({tag, "_len"},   64'(cyc - last_close), 64'(WIN_BITS));
        last_close = cyc;
        check({tag, "_valid"}, 64'(o_win_valid), 64'd1);
        check({tag, "_idx"},   64'(o_win_idx),   64'(exp_idx));
        check({tag, "_err_i"}, 64'(o_win_err_I), 64'(ei));
        check({tag, "_err_q"}, 64'(o_win_err_Q), 64'(eq));
    endtask

    task automatic check_fsm(input string tag, input logic [1:0] st, input logic [15:0] loss);
        check({tag, "_state"},  64'(o_state),    64'(st));
        check({tag, "_locked"}, 64'(o_locked),   64'(st == 2'b10));
        check({tag, "_loss"},   64'(o_loss_cnt), 64'(loss));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  64'(o_win_valid),  64'd0);
        check({tag, "_err_i"},  64'(o_win_err_I),  64'd0);
        check({tag, "_err_q"},  64'(o_win_err_Q),  64'd0);
        check({tag, "_rot"},    64'(o_win_rot),    64'd0);
        check({tag, "_idx"},    64'(o_win_idx),    64'd0);
        check({tag, "_rotchg"}, 64'(o_rot_change), 64'd0);
        check({tag, "_ovr"},    64'(o_overrun),    64'd0);
        check_fsm(tag, 2'b00, 16'd0);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_en        = 1'b0;
        i_err_cnt_I = '0;
        i_err_cnt_Q = '0;
        i_bit_cnt_I = '0;
        i_rot_ang   = 2'b00;
        i_win_ready = 1'b1;

        // Reset state
        tick_n(3);
        i_reset = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Counters sit just below 2^64 so the first window wraps through 0
        i_bit_cnt_I = 64'hFFFF_FFFF_FFFF_FF9C;
        i_err_cnt_I = 64'hFFFF_FFFF_FFFF_FFF6;
        i_err_cnt_Q = 64'hFFFF_FFFF_FFFF_FFFB;
        i_en        = 1'b1;
        tick();
        check_fsm("idle_to_acq", 2'b01, 16'd0);
        check("idle_no_result", 64'(o_win_valid), 64'd0);
        last_close = cyc;

        // Acquisition: sum 40 is the GOOD boundary
        run_window("w1", 13'd20, 13'd20, 1'b0, 16'd1);
        check("w1_rot", 64'(o_win_rot), 64'd0);
        check_fsm("w1", 2'b01, 16'd0);
        run_window("w2", 13'd0, 13'd0, 1'b0, 16'd2);
        check_fsm("w2", 2'b01, 16'd0);
        run_window("w3", 13'd0, 13'd0, 1'b0, 16'd3);
        check_fsm("w3", 2'b10, 16'd0);

        // Single bad window, good window, then two bad windows -> loss
        run_window("w4", 13'd0, 13'd50, 1'b0, 16'd4);
        check_fsm("w4", 2'b10, 16'd0);
        run_window("w5", 13'd0, 13'd0, 1'b0, 16'd5);
        check_fsm("w5", 2'b10, 16'd0);
        run_window("w6", 13'd0, 13'd50, 1'b0, 16'd6);
        check_fsm("w6", 2'b10, 16'd0);
        run_window("w7", 13'd0, 13'd50, 1'b0, 16'd7);
        check_fsm("w7", 2'b01, 16'd1);

        // Sum 41 is BAD in ACQ and restarts the good run: lock needs 9,10,11
        run_window("w8", 13'd41, 13'd0, 1'b0, 16'd8);
        check_fsm("w8", 2'b01, 16'd1);
        run_window("w9", 13'd0, 13'd0, 1'b0, 16'd9);
        run_window("w10", 13'd0, 13'd0, 1'b0, 16'd10);
        check_fsm("w10", 2'b01, 16'd1);
        run_window("w11", 13'd0, 13'd0, 1'b0, 16'd11);
        check_fsm("w11", 2'b10, 16'd1);

        // Rotation 00 -> 10 mid-window while LOCKED
        tick_n(1000);
        i_rot_ang = 2'b10;
        tick();
        last_close = cyc;
        check("rot_pulse", 64'(o_rot_change), 64'd1);
        check("rot_no_result", 64'(o_win_valid), 64'd0);
        check_fsm("rot", 2'b01, 16'd1);
        tick();
        check("rot_pulse_end", 64'(o_rot_change), 64'd0);
        run_window("w12", 13'd0, 13'd0, 1'b0, 16'd12);
        check("w12_rot", 64'(o_win_rot), 64'd2);
        check_fsm("w12", 2'b01, 16'd1);
        tick();
        check("w12_cleared", 64'(o_win_valid), 64'd0);

        // Consumer stalls; ready arrives exactly on the next close cycle
        i_win_ready = 1'b0;
        run_window("w13", 13'd1, 13'd2, 1'b0, 16'd13);
        tick_n(5);
        check("w13_held_valid", 64'(o_win_valid), 64'd1);
        check("w13_held_idx", 64'(o_win_idx), 64'd13);
        run_window("w14", 13'd5, 13'd0, 1'b1, 16'd14);
        check("w14_no_ovr", 64'(o_overrun), 64'd0);
        check_fsm("w14", 2'b10, 16'd1);

        // Second close without acceptance overwrites and flags overrun
        i_win_ready = 1'b0;
        run_window("w15", 13'd7, 13'd0, 1'b0, 16'd15);
        check("w15_ovr", 64'(o_overrun), 64'd1);
        i_win_ready = 1'b1;
        tick();
        check("w15_accepted", 64'(o_win_valid), 64'd0);
        check("w15_ovr_sticky", 64'(o_overrun), 64'd1);

        // Reset with a result pending, then restart from IDLE
        i_win_ready = 1'b0;
        run_window("w16", 13'd0, 13'd0, 1'b0, 16'd16);
        tick_n(100);
        check("w16_pending", 64'(o_win_valid), 64'd1);
        i_reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        i_reset     = 1'b0;
        i_win_ready = 1'b1;
        tick();
        check_fsm("restart", 2'b01, 16'd0);
        check("restart_no_pulse", 64'(o_rot_change), 64'd0);
        last_close = cyc;
        run_window("r1", 13'd3, 13'd4, 1'b0, 16'd1);
        check("r1_rot", 64'(o_win_rot), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
